// File: rtl/lcd_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module      : lcd_fb_scanout
// Description : Parallel RGB LCD scan-out engine. Generates the h/v timing,
//               reads the framebuffer through a synchronous-read RAM port
//               and replicates every framebuffer word into a
//               2^SCALE_SHIFT x 2^SCALE_SHIFT block of panel pixels.
//               Optional macro LCD_SCANOUT_TESTPAT_EN adds a test_pat input
//               that replaces RAM data with eight vertical colour bars.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_fb_scanout #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 13,
  parameter int H_ACTIVE    = 480,
  parameter int H_FP        = 8,
  parameter int H_SYNC      = 4,
  parameter int H_BP        = 43,
  parameter int V_ACTIVE    = 272,
  parameter int V_FP        = 8,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 12,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
`ifdef LCD_SCANOUT_TESTPAT_EN
  input  logic                  test_pat,
`endif
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  lcd_de,
  output logic                  lcd_hsync_n,
  output logic                  lcd_vsync_n,
  output logic [DATA_WIDTH-1:0] lcd_data,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

  localparam logic [HW-1:0]         H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]         H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0]         V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]         V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [SW-1:0]         SUB_MAX    = SW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_WIDTH-1:0] FB_STRIDE  = ADDR_WIDTH'(H_ACTIVE >> SCALE_SHIFT);

  // Counter-stage state
  logic                  run_q;
  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [SW-1:0]         sub_x_q, sub_x_d;
  logic [SW-1:0]         sub_y_q, sub_y_d;

  // Raw timing flags for the current counter position
  logic de_raw, hs_raw, vs_raw;

  // Delay line aligning de/syncs with the RAM read latency
  logic de_p1_q, de_p2_q, hs_p1_q, hs_p2_q, vs_p1_q, vs_p2_q;
  logic                  lcd_de_q, lcd_hs_n_q, lcd_vs_n_q;
  logic [DATA_WIDTH-1:0] lcd_data_q;
  logic [DATA_WIDTH-1:0] pix_src;

  // run_q gates everything so the idle origin never looks like live video
  assign de_raw = run_q && (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
  assign hs_raw = run_q && (int'(h_q) >= H_ACTIVE + H_FP) &&
                  (int'(h_q) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw = run_q && (int'(v_q) >= V_ACTIVE + V_FP) &&
                  (int'(v_q) < V_ACTIVE + V_FP + V_SYNC);

  // Next-state logic for counters and the incremental address generator
  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    line_base_d = line_base_q;
    ram_addr_d  = line_base_q;
    sub_x_d     = '0;
    sub_y_d     = sub_y_q;

    // The first enabled cycle stays at the origin; counting starts after it
    if (run_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end

    if (de_raw) begin
      sub_x_d = (sub_x_q == SUB_MAX) ? '0 : sub_x_q + SW'(1);
      if (h_q == '0) begin
        ram_addr_d = line_base_q;
      end else if (sub_x_q == '0) begin
        ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
      end else begin
        ram_addr_d = ram_addr_q;
      end

      // End of an active line: advance the source row every 2^S lines.
      // After the last active line the base returns to 0 so blanking never
      // presents an address past the end of the framebuffer.
      if (h_q == H_ACT_LAST) begin
        if (v_q == V_ACT_LAST) begin
          sub_y_d     = '0;
          line_base_d = '0;
        end else if (sub_y_q == SUB_MAX) begin
          sub_y_d     = '0;
          line_base_d = line_base_q + FB_STRIDE;
        end else begin
          sub_y_d     = sub_y_q + SW'(1);
        end
      end
    end
  end

  // Counter-stage registers; reset or disable parks them at the origin
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      run_q       <= 1'b0;
      h_q         <= '0;
      v_q         <= '0;
      line_base_q <= '0;
      ram_addr_q  <= '0;
      sub_x_q     <= '0;
      sub_y_q     <= '0;
    end else begin
      run_q       <= 1'b1;
      h_q         <= h_d;
      v_q         <= v_d;
      line_base_q <= line_base_d;
      ram_addr_q  <= ram_addr_d;
      sub_x_q     <= sub_x_d;
      sub_y_q     <= sub_y_d;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign frame_start = run_q && (h_q == '0) && (v_q == '0);

`ifdef LCD_SCANOUT_TESTPAT_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [BW-1:0] bar_pix_q, bar_pix_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [2:0]    bar_p1_q, bar_p2_q;
  logic [15:0]   bar_rgb;

  // Bar index tracks h_cnt*8/H_ACTIVE by stepping every H_ACTIVE/8 pixels
  always_comb begin
    bar_pix_d = '0;
    bar_idx_d = '0;
    if (de_raw) begin
      if (bar_pix_q == BAR_LAST) begin
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + BW'(1);
        bar_idx_d = bar_idx_q;
      end
    end
  end

  // Bar counters live in the counter stage
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      bar_pix_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Bar index follows de through the same two delay stages
  always_ff @(posedge clk) begin
    if (rst) begin
      bar_p1_q <= '0;
      bar_p2_q <= '0;
    end else begin
      bar_p1_q <= bar_idx_q;
      bar_p2_q <= bar_p1_q;
    end
  end

  // RGB565 colour per bar: white, yellow, cyan, green, magenta, red, blue, black
  always_comb begin
    bar_rgb = 16'h0000;
    case (bar_p2_q)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  end

  assign pix_src = test_pat ? DATA_WIDTH'(bar_rgb) : ram_dout;
`else
  assign pix_src = ram_dout;
`endif

  // Output pipeline: de/syncs delayed to match addr register + RAM latency
  always_ff @(posedge clk) begin
    if (rst) begin
      de_p1_q    <= 1'b0;
      de_p2_q    <= 1'b0;
      hs_p1_q    <= 1'b0;
      hs_p2_q    <= 1'b0;
      vs_p1_q    <= 1'b0;
      vs_p2_q    <= 1'b0;
      lcd_de_q   <= 1'b0;
      lcd_hs_n_q <= 1'b1;
      lcd_vs_n_q <= 1'b1;
      lcd_data_q <= '0;
    end else begin
      de_p1_q    <= de_raw;
      de_p2_q    <= de_p1_q;
      hs_p1_q    <= hs_raw;
      hs_p2_q    <= hs_p1_q;
      vs_p1_q    <= vs_raw;
      vs_p2_q    <= vs_p1_q;
      lcd_de_q   <= de_p2_q;
      lcd_hs_n_q <= ~hs_p2_q;
      lcd_vs_n_q <= ~vs_p2_q;
      lcd_data_q <= de_p2_q ? pix_src : '0;
    end
  end

  assign lcd_de      = lcd_de_q;
  assign lcd_hsync_n = lcd_hs_n_q;
  assign lcd_vsync_n = lcd_vs_n_q;
  assign lcd_data    = lcd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_fb_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_fb_scanout
// Description : Scoreboard bench for lcd_fb_scanout on a shrunken panel.
//               A frame-position model predicts every output cycle; a
//               separate monitor pops and compares predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_fb_scanout;

  localparam int DW  = 16;
  localparam int AW  = 6;
  localparam int HA  = 32;
  localparam int HFP = 3;
  localparam int HSW = 2;
  localparam int HBP = 4;
  localparam int VA  = 16;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int S   = 2;
  localparam int HT       = HA + HFP + HSW + HBP;
  localparam int VT       = VA + VFP + VSW + VBP;
  localparam int FRAME    = HT * VT;
  localparam int FBW      = HA >> S;
  localparam int FB_WORDS = FBW * (VA >> S);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          lcd_de, lcd_hsync_n, lcd_vsync_n, frame_start;
  logic [DW-1:0] lcd_data;
`ifdef LCD_SCANOUT_TESTPAT_EN
  logic          test_pat = 1'b1;
`endif

  lcd_fb_scanout #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SCALE_SHIFT(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
`ifdef LCD_SCANOUT_TESTPAT_EN
    .test_pat(test_pat),
`endif
    .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .lcd_de(lcd_de),
    .lcd_hsync_n(lcd_hsync_n),
    .lcd_vsync_n(lcd_vsync_n),
    .lcd_data(lcd_data),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM, one clock of latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) ram_dout <= mem[ram_addr];

  logic [15:0] bars [0:7];

  typedef struct {
    bit de;
    bit hs;
    bit vs;
    int h;
    int addr;
  } dl_t;

  typedef struct {
    bit            de;
    bit            hs_n;
    bit            vs_n;
    logic [DW-1:0] data;
    bit            fs;
    logic [AW-1:0] addr;
    bit            exact;
  } exp_t;

  exp_t exp_q[$];
  dl_t  dly[$];
  bit   m_run = 1'b0;
  int   m_pos = 0;
  bit   done = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dis_left = 0;

  function automatic dl_t inact();
    dl_t d;
    d.de = 1'b0; d.hs = 1'b0; d.vs = 1'b0; d.h = 0; d.addr = 0;
    return d;
  endfunction

  function automatic logic [DW-1:0] pix_of(input dl_t o);
`ifdef LCD_SCANOUT_TESTPAT_EN
    return bars[(o.h * 8) / HA];
`else
    return mem[o.addr];
`endif
  endfunction

  // Reference: the panel is a frame position that advances one step per
  // enabled clock; outputs show that position three clocks later.
  task automatic step_model(input bit r, input bit en);
    dl_t  pre, o;
    exp_t e;
    int   h, v, a;
    h = m_pos % HT;
    v = m_pos / HT;
    pre.de = m_run && (h < HA) && (v < VA);
    pre.hs = m_run && (h >= HA + HFP) && (h < HA + HFP + HSW);
    pre.vs = m_run && (v >= VA + VFP) && (v < VA + VFP + VSW);
    pre.h  = h;
    if (r || !en) begin
      a = 0; e.exact = 1'b1;
    end else if (pre.de) begin
      a = (v >> S) * FBW + (h >> S); e.exact = 1'b1;
    end else begin
      a = 0; e.exact = 1'b0;
    end
    pre.addr = a;
    if (r || !en) begin
      m_run = 1'b0; m_pos = 0;
    end else if (!m_run) begin
      m_run = 1'b1; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
    end
    if (r) begin
      dly.delete();
      dly.push_back(inact());
      dly.push_back(inact());
      o = inact();
    end else begin
      dly.push_back(pre);
      o = dly.pop_front();
    end
    e.de   = o.de;
    e.hs_n = !o.hs;
    e.vs_n = !o.vs;
    e.data = o.de ? pix_of(o) : '0;
    e.fs   = m_run && (m_pos == 0);
    e.addr = a[AW-1:0];
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit en);
    @(negedge clk);
    rst = r;
    enable = en;
    @(posedge clk);
    step_model(r, en);
  endtask

  // Stimulus
  initial begin
    bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
    bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;
    for (int k = 0; k < (1 << AW); k++)
      mem[k] = (k < FB_WORDS) ? 16'($urandom) : 16'hDEAD;
    dly.push_back(inact());
    dly.push_back(inact());

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 2 * FRAME + 10; i++) drive(1'b0, 1'b1);

    // One-clock reset in the middle of an active line
    for (int i = 0; i < FRAME; i++) begin
      if (m_pos == 10 * HT + 20) break;
      drive(1'b0, 1'b1);
    end
    drive(1'b1, 1'b1);
    for (int i = 0; i < FRAME + 20; i++) drive(1'b0, 1'b1);

    // 50-clock enable drop mid-line, then a full frame
    for (int i = 0; i < FRAME; i++) begin
      if (m_pos == 5 * HT + 10) break;
      drive(1'b0, 1'b1);
    end
    for (int i = 0; i < 50; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < FRAME + 20; i++) drive(1'b0, 1'b1);

    // Random resets and enable drops
    for (int i = 0; i < 3000; i++) begin
      bit r, en;
      r = 1'b0;
      en = 1'b1;
      if (dis_left > 0) begin
        en = 1'b0;
        dis_left--;
      end else if ($urandom_range(0, 399) == 0) begin
        r = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        dis_left = int'($urandom_range(1, 60));
      end
      drive(r, en);
    end
    for (int i = 0; i < FRAME + 5; i++) drive(1'b0, 1'b1);
    done = 1'b1;
  end

  // Monitor: one predicted output set per clock
  initial begin
    exp_t e;
    while (!(done && exp_q.size() == 0)) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (lcd_de !== e.de || lcd_hsync_n !== e.hs_n || lcd_vsync_n !== e.vs_n ||
            lcd_data !== e.data) begin
          n_bad++;
          $display("FAIL lcd_out t=%0t got de=%b hs_n=%b vs_n=%b data=%h want de=%b hs_n=%b vs_n=%b data=%h",
                   $time, lcd_de, lcd_hsync_n, lcd_vsync_n, lcd_data,
                   e.de, e.hs_n, e.vs_n, e.data);
        end
        n_cmp++;
        if (frame_start !== e.fs) begin
          n_bad++;
          $display("FAIL frame_start t=%0t got %b want %b", $time, frame_start, e.fs);
        end
        n_cmp++;
        if (e.exact) begin
          if (ram_addr !== e.addr) begin
            n_bad++;
            $display("FAIL ram_addr t=%0t got %0d want %0d", $time, ram_addr, e.addr);
          end
        end else if ($isunknown(ram_addr) || int'(ram_addr) >= FB_WORDS) begin
          n_bad++;
          $display("FAIL ram_addr_bound t=%0t got %0d want < %0d", $time, ram_addr, FB_WORDS);
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
